// File: rtl/rv_sequencer_pkg.sv
// rv_pkg: shared definitions for the multi-cycle RV32I control sequencer.
//   state_t   - sequencer state codes (also exported on the debug state port)
//   OP_*      - RV32I major opcodes, instr[6:0]
//   is_wb_op  - opcodes that write a register result and retire in EXECUTE
package rv_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_INSTR = 3'd0,
    ST_WAIT_INSTR  = 3'd1,
    ST_FETCH_REGS  = 3'd2,
    ST_EXECUTE     = 3'd3,
    ST_LOAD        = 3'd4,
    ST_WAIT_DATA   = 3'd5,
    ST_STORE       = 3'd6,
    ST_HALT        = 3'd7
  } state_t;

  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic is_wb_op(input logic [6:0] op);
    return (op == OP_ALUREG) || (op == OP_ALUIMM) || (op == OP_LUI) ||
           (op == OP_AUIPC)  || (op == OP_JAL)    || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/rv_sequencer_if.sv
// rv_sequencer_if: memory handshake between the sequencer and instruction/data memory.
//   mem_rstrb  read request, 1-cycle pulse
//   mem_wstrb  write request, held until mem_ready
//   addr_sel   0 = address from PC, 1 = load/store address
//   mem_ready  access complete (level, sampled every clock)
// master = sequencer side, slave = memory side.
interface rv_sequencer_if;
  logic mem_rstrb;
  logic mem_wstrb;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_rstrb, output mem_wstrb, output addr_sel, input mem_ready);
  modport slave  (input mem_rstrb, input mem_wstrb, input addr_sel, output mem_ready);
endinterface

// File: rtl/rv_bus_watchdog.sv
// rv_bus_watchdog: bounds the time spent waiting on mem_ready.
//   clk, resetn  clock, async active-low reset
//   clear        reload the timer (asserted whenever the sequencer is not waiting)
//   count_en     a wait cycle without mem_ready
//   expired      this is the TIMEOUT-th consecutive wait cycle without mem_ready
// Down-counter loaded with TIMEOUT-1; terminal count is zero, so the expiry
// decision is made in the same cycle as the last tolerated wait.
module rv_bus_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [15:0] RELOAD = 16'(TIMEOUT - 1);

  logic [15:0] remaining;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      remaining <= RELOAD;
    end else if (clear) begin
      remaining <= RELOAD;
    end else if (count_en && (remaining != 16'd0)) begin
      remaining <= remaining - 16'd1;
    end
  end

  assign expired = count_en && (remaining == 16'd0);

endmodule

// File: rtl/rv_sequencer.sv
// rv_sequencer: control FSM of the multi-cycle RV32I core.
//   clk, resetn         core clock, async active-low reset
//   run                 allow new fetches (only looked at in FETCH_INSTR)
//   resume              pulse: leave HALT and clear sticky flags
//   opcode, rd_nz       decoder inputs
//   mem                 memory handshake (rv_sequencer_if.master)
//   instr_ld, regs_ld, pc_we, wb_en, wb_sel_load   datapath enables
//   halted, illegal, bus_err, state                status / debug
//   cycle_cnt, instret_cnt                         free-running wrap counters
//
// state       | meaning
// FETCH_INSTR | idle / issue instruction read when run=1
// WAIT_INSTR  | waiting for instruction word
// FETCH_REGS  | latch rs1/rs2
// EXECUTE     | ALU/branch/jump, dispatch loads, stores, halt
// LOAD        | issue data read
// WAIT_DATA   | waiting for load data, write back on ready
// STORE       | write strobe held until ready
// HALT        | stopped (EBREAK, illegal opcode, bus timeout)
module rv_sequencer
  import rv_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 run,
  input  logic                 resume,
  input  logic [6:0]           opcode,
  input  logic                 rd_nz,
  rv_sequencer_if.master       mem,
  output logic                 instr_ld,
  output logic                 regs_ld,
  output logic                 pc_we,
  output logic                 wb_en,
  output logic                 wb_sel_load,
  output logic                 halted,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  state_t cur, nxt;
  logic   rstrb, wstrb, asel;
  logic   retire, set_illegal, set_bus_err, clear_flags;
  logic   in_wait, wd_expired;

  assign in_wait = (cur == ST_WAIT_INSTR) || (cur == ST_WAIT_DATA) || (cur == ST_STORE);

  rv_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (!in_wait),
    .count_en (in_wait && !mem.mem_ready),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur         <= ST_FETCH_INSTR;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cur <= nxt;
      if (clear_flags) begin
        illegal <= 1'b0;
        bus_err <= 1'b0;
      end else begin
        if (set_illegal) illegal <= 1'b1;
        if (set_bus_err) bus_err <= 1'b1;
      end
      if (cur != ST_HALT) cycle_cnt <= cycle_cnt + CNT_ONE;
      if (retire) instret_cnt <= instret_cnt + CNT_ONE;
    end
  end

  always_comb begin
    nxt         = cur;
    rstrb       = 1'b0;
    wstrb       = 1'b0;
    asel        = 1'b0;
    instr_ld    = 1'b0;
    regs_ld     = 1'b0;
    pc_we       = 1'b0;
    wb_en       = 1'b0;
    wb_sel_load = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    clear_flags = 1'b0;
    case (cur)
      ST_FETCH_INSTR: begin
        if (run) begin
          rstrb = 1'b1;
          nxt   = ST_WAIT_INSTR;
        end
      end
      ST_WAIT_INSTR: begin
        // a ready arriving in the expiry cycle still completes normally
        if (mem.mem_ready) begin
          instr_ld = 1'b1;
          nxt      = ST_FETCH_REGS;
        end else if (wd_expired) begin
          set_bus_err = 1'b1;
          nxt         = ST_HALT;
        end
      end
      ST_FETCH_REGS: begin
        regs_ld = 1'b1;
        nxt     = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (is_wb_op(opcode)) begin
          wb_en  = rd_nz;
          pc_we  = 1'b1;
          retire = 1'b1;
          nxt    = ST_FETCH_INSTR;
        end else begin
          case (opcode)
            OP_BRANCH: begin
              pc_we  = 1'b1;
              retire = 1'b1;
              nxt    = ST_FETCH_INSTR;
            end
            OP_LOAD: begin
              pc_we = 1'b1;
              nxt   = ST_LOAD;
            end
            OP_STORE: begin
              pc_we = 1'b1;
              nxt   = ST_STORE;
            end
            OP_SYSTEM: begin
              retire = 1'b1;
              nxt    = ST_HALT;
            end
            default: begin
              set_illegal = 1'b1;
              nxt         = ST_HALT;
            end
          endcase
        end
      end
      ST_LOAD: begin
        rstrb = 1'b1;
        asel  = 1'b1;
        nxt   = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        asel = 1'b1;
        if (mem.mem_ready) begin
          wb_en       = rd_nz;
          wb_sel_load = 1'b1;
          retire      = 1'b1;
          nxt         = ST_FETCH_INSTR;
        end else if (wd_expired) begin
          set_bus_err = 1'b1;
          nxt         = ST_HALT;
        end
      end
      ST_STORE: begin
        wstrb = 1'b1;
        asel  = 1'b1;
        if (mem.mem_ready) begin
          retire = 1'b1;
          nxt    = ST_FETCH_INSTR;
        end else if (wd_expired) begin
          set_bus_err = 1'b1;
          nxt         = ST_HALT;
        end
      end
      ST_HALT: begin
        if (resume) begin
          clear_flags = 1'b1;
          nxt         = ST_FETCH_INSTR;
        end
      end
      default: nxt = ST_FETCH_INSTR;
    endcase
  end

  // FETCH_INSTR is the reset state; keep the fetch strobe quiet while reset is held
  assign mem.mem_rstrb = rstrb && resetn;
  assign mem.mem_wstrb = wstrb;
  assign mem.addr_sel  = asel;
  assign halted        = (cur == ST_HALT);
  assign state         = cur;

endmodule

// File: tb/tb_rv_sequencer.sv
// tb_rv_sequencer: randomized scoreboard bench for rv_sequencer.
// The driver issues one instruction at a time with chosen memory latencies and
// pushes the expected outcome from an instruction-level model; a monitor
// collects what the DUT did over each instruction and compares on completion.
module tb_rv_sequencer;
  import rv_pkg::*;

  localparam int TO = 4;
  localparam int CW = 4;
  localparam int CMOD = 1 << CW;

  typedef struct {
    int len; int pc_we; int wb_en; int wb_sel; int rstrb; int wstrb; int instr_ld;
    int end_state; int retire; int illegal; int bus_err; int instret; int cycle;
  } exp_t;

  logic clk, resetn, run, resume, rd_nz;
  logic [6:0] opcode;
  logic instr_ld, regs_ld, pc_we, wb_en, wb_sel_load, halted, illegal, bus_err;
  logic [2:0] state;
  logic [CW-1:0] cycle_cnt, instret_cnt;

  rv_sequencer_if bus();

  rv_sequencer #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .run(run), .resume(resume), .opcode(opcode),
    .rd_nz(rd_nz), .mem(bus), .instr_ld(instr_ld), .regs_ld(regs_ld), .pc_we(pc_we),
    .wb_en(wb_en), .wb_sel_load(wb_sel_load), .halted(halted), .illegal(illegal),
    .bus_err(bus_err), .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  exp_t sb[$];
  int fetch_lat = 0;
  int data_lat = 0;
  int model_cycle = 0;
  int model_instret = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // instruction-level reference: cycles spent and enables seen per instruction
  function automatic exp_t model(input logic [6:0] op, input bit rdnz, input int fl, input int dl);
    exp_t e;
    e = '{default: 0};
    e.len = 1;
    e.rstrb = 1;
    if (fl >= TO) begin
      e.len += TO; e.bus_err = 1; e.end_state = 7;
      return e;
    end
    e.len += fl + 1 + 2;
    e.instr_ld = 1;
    if (op == OP_ALUREG || op == OP_ALUIMM || op == OP_LUI || op == OP_AUIPC ||
        op == OP_JAL || op == OP_JALR) begin
      e.pc_we = 1; e.wb_en = rdnz; e.retire = 1;
    end else if (op == OP_BRANCH) begin
      e.pc_we = 1; e.retire = 1;
    end else if (op == OP_LOAD) begin
      e.pc_we = 1; e.len += 1; e.rstrb = 2;
      if (dl >= TO) begin
        e.len += TO; e.bus_err = 1; e.end_state = 7;
      end else begin
        e.len += dl + 1; e.wb_en = rdnz; e.wb_sel = 1; e.retire = 1;
      end
    end else if (op == OP_STORE) begin
      e.pc_we = 1;
      if (dl >= TO) begin
        e.len += TO; e.wstrb = TO; e.bus_err = 1; e.end_state = 7;
      end else begin
        e.len += dl + 1; e.wstrb = dl + 1; e.retire = 1;
      end
    end else if (op == OP_SYSTEM) begin
      e.retire = 1; e.end_state = 7;
    end else begin
      e.illegal = 1; e.end_state = 7;
    end
    return e;
  endfunction

  // memory: answers after a programmed number of wait cycles
  int resp_cnt = 0;
  always @(negedge clk) begin
    if (!resetn) begin
      bus.mem_ready <= 1'b0;
      resp_cnt <= 0;
    end else if (state == 3'd1) begin
      bus.mem_ready <= (resp_cnt == fetch_lat);
      resp_cnt <= resp_cnt + 1;
    end else if (state == 3'd5 || state == 3'd6) begin
      bus.mem_ready <= (resp_cnt == data_lat);
      resp_cnt <= resp_cnt + 1;
    end else begin
      bus.mem_ready <= 1'b0;
      resp_cnt <= 0;
    end
  end

  // monitor
  initial begin
    bit active;
    int m_len, m_pc, m_wb, m_sel, m_rs, m_ws, m_il;
    exp_t e;
    active = 0;
    m_len = 0; m_pc = 0; m_wb = 0; m_sel = 0; m_rs = 0; m_ws = 0; m_il = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        active = 0;
      end else begin
        if (active && (state == 3'd0 || state == 3'd7)) begin
          active = 0;
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            check("len", m_len, e.len);
            check("end_state", int'(state), e.end_state);
            check("halted", int'(halted), int'(e.end_state == 7));
            check("illegal", int'(illegal), e.illegal);
            check("bus_err", int'(bus_err), e.bus_err);
            check("instret", int'(instret_cnt), e.instret);
            check("cycle", int'(cycle_cnt), e.cycle);
            check("pc_we", m_pc, e.pc_we);
            check("wb_en", m_wb, e.wb_en);
            check("wb_sel_load", m_sel, e.wb_sel);
            check("mem_rstrb", m_rs, e.rstrb);
            check("mem_wstrb", m_ws, e.wstrb);
            check("instr_ld", m_il, e.instr_ld);
          end
        end
        if (!active && state == 3'd0 && bus.mem_rstrb) begin
          active = 1;
          m_len = 0; m_pc = 0; m_wb = 0; m_sel = 0; m_rs = 0; m_ws = 0; m_il = 0;
        end
        if (active) begin
          m_len++;
          m_pc  += int'(pc_we);
          m_wb  += int'(wb_en);
          m_sel += int'(wb_sel_load);
          m_rs  += int'(bus.mem_rstrb);
          m_ws  += int'(bus.mem_wstrb);
          m_il  += int'(instr_ld);
        end
      end
    end
  end

  task automatic issue(input logic [6:0] op, input bit rdnz, input int fl, input int dl);
    exp_t e;
    bit done;
    opcode = op; rd_nz = rdnz; fetch_lat = fl; data_lat = dl;
    e = model(op, rdnz, fl, dl);
    model_cycle = (model_cycle + e.len) % CMOD;
    model_instret = (model_instret + e.retire) % CMOD;
    e.instret = model_instret;
    e.cycle = model_cycle;
    sb.push_back(e);
    run = 1'b1;
    @(negedge clk); #1;
    run = 1'b0;
    done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (state == 3'd0 || state == 3'd7) begin
        done = 1;
        break;
      end
    end
    if (!done) check("complete_timeout", 0, 1);
    if (state == 3'd7) begin
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
        @(negedge clk); #1;
        check("halt_cycle_frozen", int'(cycle_cnt), model_cycle);
      end
      resume = 1'b1;
      @(negedge clk); #1;
      resume = 1'b0;
      check("resume_state", int'(state), 0);
      check("resume_flags", int'({illegal, bus_err, halted}), 0);
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      resume = ($urandom_range(0, 3) == 0);
      check("idle_rstrb", int'(bus.mem_rstrb), 0);
      @(negedge clk); #1;
      resume = 1'b0;
      model_cycle = (model_cycle + 1) % CMOD;
      check("idle_state", int'(state), 0);
      check("idle_cycle", int'(cycle_cnt), model_cycle);
    end
  endtask

  logic [6:0] op_list [12];

  initial begin
    int idx;
    bit seen;
    op_list[0] = OP_ALUREG; op_list[1] = OP_ALUIMM; op_list[2] = OP_BRANCH;
    op_list[3] = OP_JALR;   op_list[4] = OP_JAL;    op_list[5] = OP_AUIPC;
    op_list[6] = OP_LUI;    op_list[7] = OP_LOAD;   op_list[8] = OP_STORE;
    op_list[9] = OP_SYSTEM; op_list[10] = 7'h7F;    op_list[11] = 7'h00;

    resetn = 1'b0; run = 1'b1; resume = 1'b0; opcode = OP_ALUIMM; rd_nz = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_rstrb", int'(bus.mem_rstrb), 0);
    check("rst_counters", int'({cycle_cnt, instret_cnt}), 0);
    check("rst_flags", int'({illegal, bus_err, halted}), 0);
    resetn = 1'b1;

    // ADDI x1,x0,1 straight out of reset: 4 cycles, instret 1
    issue(OP_ALUIMM, 1'b1, 0, 0);
    check("addi_cycle_abs", int'(cycle_cnt), 4);
    check("addi_instret_abs", int'(instret_cnt), 1);
    idle(2);
    issue(OP_LOAD, 1'b1, 0, 3);          // LW, data three cycles late
    issue(OP_STORE, 1'b0, 1, 1000);      // SW never acknowledged -> bus error
    issue(7'h7F, 1'b1, 0, 0);            // unknown opcode
    issue(OP_SYSTEM, 1'b0, 2, 0);        // EBREAK
    issue(OP_LOAD, 1'b1, TO - 1, TO - 1);  // ready on the expiry cycle wins
    issue(OP_LOAD, 1'b0, 0, TO);           // one cycle too late
    issue(OP_ALUREG, 1'b1, TO, 0);         // instruction fetch timeout

    // async reset in WAIT_DATA
    opcode = OP_LOAD; rd_nz = 1'b1; fetch_lat = 0; data_lat = 50;
    run = 1'b1;
    @(negedge clk); #1;
    run = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (state == 3'd5) begin
        seen = 1;
        break;
      end
    end
    check("reach_wait_data", int'(seen), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_addr_sel", int'(bus.addr_sel), 0);
    check("async_rst_counters", int'({cycle_cnt, instret_cnt}), 0);
    check("async_rst_strobes", int'({bus.mem_rstrb, bus.mem_wstrb, wb_en}), 0);
    repeat (2) @(negedge clk);
    #1;
    resetn = 1'b1;
    model_cycle = 0;
    model_instret = 0;

    for (int n = 0; n < 80; n++) begin
      int fl, dl;
      idx = $urandom_range(0, 11);
      fl = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
      dl = ($urandom_range(0, 4) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
      issue(op_list[idx], 1'($urandom_range(0, 1)), fl, dl);
      idle($urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d, expected %0d", 0, 1);
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
